// File: rtl/dca_matrix_row_assembler.sv
// Assembles tensor rows from memory beats: each command yields MATRIX_SIZE rows,
// with rows >= R and columns >= C forced to zero.
module dca_matrix_row_assembler #(
    parameter int MATRIX_SIZE      = 8,
    parameter int BW_TENSOR_SCALAR = 32,
    parameter int BW_MEM_DATA      = 64,
    localparam int BW_ROW          = MATRIX_SIZE * BW_TENSOR_SCALAR,
    localparam int SPB             = BW_MEM_DATA / BW_TENSOR_SCALAR,
    localparam int BW_DIM          = $clog2(MATRIX_SIZE + 1)
) (
    input  logic              clk,
    input  logic              rstnn,
    input  logic              clear,
    input  logic              enable,
    output logic              busy,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [BW_DIM-1:0] cmd_num_row,
    input  logic [BW_DIM-1:0] cmd_num_col,
    input  logic              mem_rvalid,
    output logic              mem_rready,
    input  logic [BW_MEM_DATA-1:0] mem_rdata,
    input  logic              load_tensor_row_wready,
    output logic              load_tensor_row_wvalid,
    output logic              load_tensor_row_wlast,
    output logic [BW_ROW-1:0] load_tensor_row_wdata
);

    localparam int BEATS_MAX = BW_ROW / BW_MEM_DATA;

    typedef enum logic [1:0] {IDLE, FILL, EMIT, PAD} state_t;

    state_t            state, state_next;
    logic [BW_DIM-1:0] num_row, num_col, bpr;
    logic [BW_DIM-1:0] row_cnt, beat_cnt;
    logic [BW_ROW-1:0] row_reg, col_mask;
    logic [BW_DIM-1:0] r_clamp, c_clamp, bpr_calc;
    logic              cmd_fire, beat_fire, row_fire;
    logic              row_last, beat_last;

    assign cmd_fire  = enable & cmd_valid & (state == IDLE);
    assign beat_fire = enable & mem_rvalid & (state == FILL);
    assign row_fire  = enable & load_tensor_row_wready & ((state == EMIT) || (state == PAD));
    assign row_last  = (row_cnt == BW_DIM'(MATRIX_SIZE - 1));
    assign beat_last = (beat_cnt == bpr - BW_DIM'(1));

    always_comb begin
        r_clamp  = (cmd_num_row > BW_DIM'(MATRIX_SIZE)) ? BW_DIM'(MATRIX_SIZE) : cmd_num_row;
        c_clamp  = (cmd_num_col > BW_DIM'(MATRIX_SIZE)) ? BW_DIM'(MATRIX_SIZE) : cmd_num_col;
        // one extra bit so the ceil-divide rounding cannot overflow
        bpr_calc = BW_DIM'(({1'b0, c_clamp} + (BW_DIM + 1)'(SPB - 1)) / (BW_DIM + 1)'(SPB));
    end

    always_comb begin
        col_mask = '0;
        for (int unsigned j = 0; j < MATRIX_SIZE; j++) begin
            col_mask[j*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR] =
                (BW_DIM'(j) < num_col) ? {BW_TENSOR_SCALAR{1'b1}} : {BW_TENSOR_SCALAR{1'b0}};
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state    <= IDLE;
            num_row  <= '0;
            num_col  <= '0;
            bpr      <= '0;
            row_cnt  <= '0;
            beat_cnt <= '0;
            row_reg  <= '0;
        end else if (clear) begin
            state    <= IDLE;
            num_row  <= '0;
            num_col  <= '0;
            bpr      <= '0;
            row_cnt  <= '0;
            beat_cnt <= '0;
            row_reg  <= '0;
        end else if (enable) begin
            state <= state_next;
            if (cmd_fire) begin
                num_row  <= r_clamp;
                num_col  <= c_clamp;
                bpr      <= bpr_calc;
                row_cnt  <= '0;
                beat_cnt <= '0;
            end
            if (beat_fire) begin
                for (int unsigned k = 0; k < BEATS_MAX; k++) begin
                    if (beat_cnt == BW_DIM'(k))
                        row_reg[k*BW_MEM_DATA +: BW_MEM_DATA] <= mem_rdata;
                end
                beat_cnt <= beat_last ? '0 : beat_cnt + BW_DIM'(1);
            end
            if (row_fire)
                row_cnt <= row_last ? '0 : row_cnt + BW_DIM'(1);
        end
    end

    always_comb begin
        state_next             = state;
        cmd_ready              = 1'b0;
        mem_rready             = 1'b0;
        load_tensor_row_wvalid = 1'b0;
        load_tensor_row_wlast  = 1'b0;
        load_tensor_row_wdata  = '0;
        case (state)
            IDLE: begin
                cmd_ready = enable;
                if (cmd_fire)
                    state_next = ((r_clamp != '0) && (c_clamp != '0)) ? FILL : PAD;
            end
            FILL: begin
                mem_rready = enable;
                if (beat_fire && beat_last)
                    state_next = EMIT;
            end
            EMIT: begin
                load_tensor_row_wvalid = enable;
                load_tensor_row_wlast  = row_last;
                load_tensor_row_wdata  = row_reg & col_mask;
                if (row_fire) begin
                    if (row_last)
                        state_next = IDLE;
                    else if (row_cnt == num_row - BW_DIM'(1))
                        state_next = PAD;
                    else
                        state_next = FILL;
                end
            end
            PAD: begin
                load_tensor_row_wvalid = enable;
                load_tensor_row_wlast  = row_last;
                if (row_fire && row_last)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dca_matrix_row_assembler.sv
// Directed bench for dca_matrix_row_assembler with 8x8 tiles of 32-bit scalars on 64-bit beats.
module tb_dca_matrix_row_assembler;

    logic         clk = 1'b0;
    logic         rstnn, clear, enable;
    logic         busy, cmd_valid, cmd_ready;
    logic [3:0]   cmd_num_row, cmd_num_col;
    logic         mem_rvalid, mem_rready;
    logic [63:0]  mem_rdata;
    logic         wready, wvalid, wlast;
    logic [255:0] wdata;

    int n_vec  = 0;
    int n_miss = 0;

    // beat source and row collector state, each owned by the posedge process
    int beat_idx  = 0;
    int beat_start = 0;
    int beat_base  = 0;
    int rows_seen  = 0;
    logic [255:0] row_data [64];
    logic         row_last [64];

    dca_matrix_row_assembler #(
        .MATRIX_SIZE(8),
        .BW_TENSOR_SCALAR(32),
        .BW_MEM_DATA(64)
    ) dut (
        .clk(clk),
        .rstnn(rstnn),
        .clear(clear),
        .enable(enable),
        .busy(busy),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_num_row(cmd_num_row),
        .cmd_num_col(cmd_num_col),
        .mem_rvalid(mem_rvalid),
        .mem_rready(mem_rready),
        .mem_rdata(mem_rdata),
        .load_tensor_row_wready(wready),
        .load_tensor_row_wvalid(wvalid),
        .load_tensor_row_wlast(wlast),
        .load_tensor_row_wdata(wdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = {32'(beat_base + 2*(beat_idx - beat_start) + 1),
                        32'(beat_base + 2*(beat_idx - beat_start))};

    always @(posedge clk) begin
        if (rstnn && !clear && enable && wvalid && wready) begin
            row_data[rows_seen % 64] <= wdata;
            row_last[rows_seen % 64] <= wlast;
            rows_seen <= rows_seen + 1;
        end
        if (rstnn && !clear && enable && mem_rvalid && mem_rready)
            beat_idx <= beat_idx + 1;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // row r of a tile whose beats carry scalars base, base+1, ... in order
    function automatic logic [255:0] exp_row(input int r, input int rr, input int cc, input int base);
        logic [255:0] v;
        int bpr;
        v   = '0;
        bpr = (cc + 1) / 2;
        if (r < rr && cc > 0)
            for (int j = 0; j < cc; j++) v[j*32 +: 32] = 32'(base + 2*bpr*r + j);
        return v;
    endfunction

    task automatic run_tile(input int r, input int c, input int base, input int stall_len,
                            input int exp_beats, input int exp_cycles, input string tag);
        int rr, cc, r0, cycles, stalled, rready_hi, overlap, rdy_busy;
        bit stall_ok;
        logic [255:0] held_data;
        logic held_last;
        rr = (r > 8) ? 8 : r;
        cc = (c > 8) ? 8 : c;
        beat_start = beat_idx;
        beat_base  = base;
        r0 = rows_seen;
        cycles = 0; stalled = 0; rready_hi = 0; overlap = 0; rdy_busy = 0;
        stall_ok = 1'b1; held_data = '0; held_last = 1'b0;
        cmd_num_row = 4'(r);
        cmd_num_col = 4'(c);
        cmd_valid   = 1'b1;
        wready      = 1'b1;
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, "_busy"}, busy, 1);
        while ((rows_seen - r0) < 8 && cycles < 300) begin
            if (mem_rready && wvalid) overlap++;
            if (mem_rready) rready_hi++;
            if (cmd_ready) rdy_busy++;
            if (stall_len > 0 && wvalid && (rows_seen - r0) == 2 && stalled < stall_len) begin
                if (stalled == 0) begin
                    held_data = wdata;
                    held_last = wlast;
                end else if (wdata !== held_data || wlast !== held_last) begin
                    stall_ok = 1'b0;
                end
                if (mem_rready) stall_ok = 1'b0;
                wready = 1'b0;
                stalled++;
            end else begin
                if (stalled == stall_len && stall_len > 0 && (rows_seen - r0) == 2 &&
                    (!wvalid || wdata !== held_data)) stall_ok = 1'b0;
                wready = 1'b1;
            end
            @(negedge clk);
            cycles++;
        end
        check({tag, "_rows"}, rows_seen - r0, 8);
        check({tag, "_cycles"}, cycles, exp_cycles);
        check({tag, "_beats"}, beat_idx - beat_start, exp_beats);
        check({tag, "_overlap"}, overlap, 0);
        check({tag, "_rdy_busy"}, rdy_busy, 0);
        if (exp_beats == 0) check({tag, "_rready_hi"}, rready_hi, 0);
        if (stall_len > 0) check({tag, "_stall_hold"}, stall_ok, 1);
        check({tag, "_idle"}, busy, 0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_row%0d", tag, i), row_data[(r0 + i) % 64], exp_row(i, rr, cc, base));
            check($sformatf("%s_last%0d", tag, i), row_last[(r0 + i) % 64], (i == 7) ? 1 : 0);
        end
    endtask

    initial begin
        int n;
        rstnn = 1'b0; clear = 1'b0; enable = 1'b0;
        cmd_valid = 1'b0; cmd_num_row = '0; cmd_num_col = '0;
        mem_rvalid = 1'b1; wready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rready", mem_rready, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_wlast", wlast, 0);
        check("rst_wdata", wdata, 0);

        // enable low: commands are ignored
        rstnn = 1'b1;
        cmd_num_row = 4'd8; cmd_num_col = 4'd8; cmd_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("en_low_ready", cmd_ready, 0);
        check("en_low_busy", busy, 0);
        cmd_valid = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        check("en_high_ready", cmd_ready, 1);

        run_tile(8, 8, 0, 0, 32, 40, "full");
        run_tile(3, 5, 100, 0, 9, 17, "r3c5");
        run_tile(8, 8, 200, 5, 32, 45, "stall");
        run_tile(0, 4, 300, 0, 0, 8, "r0");
        run_tile(15, 3, 400, 0, 16, 24, "clamp");

        // clear partway through FILL
        beat_start = beat_idx; beat_base = 1000;
        cmd_num_row = 4'd8; cmd_num_col = 4'd8; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while ((beat_idx - beat_start) < 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("clr_in_fill", {busy, mem_rready}, 2'b11);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_busy", busy, 0);
        check("clr_cmd_ready", cmd_ready, 1);
        check("clr_wvalid", wvalid, 0);
        check("clr_beats", beat_idx - beat_start, 2);
        run_tile(1, 2, 500, 0, 1, 9, "clr_next");

        // asynchronous reset while a row is presented
        beat_start = beat_idx; beat_base = 0;
        cmd_num_row = 4'd8; cmd_num_col = 4'd8; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!wvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("arst_pre_wvalid", wvalid, 1);
        rstnn = 1'b0;
        #1;
        check("arst_wvalid", wvalid, 0);
        check("arst_busy", busy, 0);
        check("arst_rready", mem_rready, 0);
        check("arst_wlast", wlast, 0);
        check("arst_wdata", wdata, 0);
        @(negedge clk);
        @(negedge clk);
        rstnn = 1'b1;
        @(negedge clk);
        run_tile(8, 8, 0, 0, 32, 40, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
